idex_stage_reg: RTL and testbench
=================================

IDEX_STAGE_REG -- requirements
Module: idex_stage_reg

Interface
REQ-001 Parameter XLEN, default 32, data/PC width.
REQ-002 Parameter CTRL_W, default 8, packed control width {alu_op[3:0], alu_src, reg_wr_en, mem_rd_en, mem_wr_en}, alu_op in MSBs.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 valid_ID  in  1  ID holds a real instruction.
REQ-006 pc_ID  in  XLEN  instruction PC.
REQ-007 rs1_data_ID, rs2_data_ID  in  XLEN each  register-file read data.
REQ-008 imm_ID  in  XLEN  sign-extended immediate.
REQ-009 rs1_ID, rs2_ID, rd_ID  in  5 each  register indices.
REQ-010 ctrl_ID  in  CTRL_W  decoded control bundle.
REQ-011 flush_EX  in  1  taken branch/jump resolved in EX; kill ID instruction.
REQ-012 hold_MEM  in  1  downstream memory busy; freeze this register.
REQ-013 stall_ID  out  1  combinational; freeze PC and IF/ID this cycle.
REQ-014 valid_IDEX, pc_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX, ctrl_IDEX  out  widths as ID counterparts  registered fields; rs1_IDEX/rs2_IDEX/rd_IDEX and ctrl_IDEX reg_wr_en bit feed the EX forwarding logic.

Function
REQ-015 Load-use hazard lu = valid_IDEX & mem_rd_en_IDEX & valid_ID & (rd_IDEX != 0) & ((rs1_ID == rd_IDEX) | (rs2_ID == rd_IDEX)).
REQ-016 stall_ID = (lu & ~flush_EX) | hold_MEM.
REQ-017 Per-edge priority: flush_EX > hold_MEM > lu > normal load.
REQ-018 flush_EX: next valid_IDEX = 0, next ctrl_IDEX = 0; other fields don't-care but held.
REQ-019 hold_MEM (no flush): every IDEX field keeps its value.
REQ-020 lu (no flush, no hold): bubble -- valid_IDEX = 0, ctrl_IDEX = 0; ID instruction held by stall_ID and re-presented next cycle.
REQ-021 Normal load: every *_IDEX <= *_ID, one-cycle latency.
REQ-022 valid_ID = 0 on normal load: valid_IDEX = 0 and ctrl_IDEX forced to 0 (no stray writes).
REQ-023 Invariant: valid_IDEX = 0 implies ctrl_IDEX = 0.
REQ-024 rd_IDEX = 0 never raises lu, even with mem_rd_en set.
REQ-025 lu lasts at most one cycle per load: the bubble clears mem_rd_en_IDEX.

Reset
REQ-026 rst_n low: all *_IDEX outputs 0 immediately, regardless of clk; stall_ID reflects only hold_MEM.
REQ-027 Reset asserted mid-stall/bubble drops the pending instruction; first post-reset edge performs a normal load.

Configuration
REQ-028 Macro IDEX_PERF_CNT_EN defined: adds outputs bubble_cnt (32, lu bubbles) and flush_cnt (32, flush edges), each saturating at 0xFFFFFFFF and reset to 0.
REQ-029 Macro undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-030 CTRL_W, ctrl bit positions, alu_op encodings and the 5-bit register-index type live in shared package pipeline_pkg.
REQ-031 Load-use detection is sub-module idex_hazard_detect (combinational: ID indices + IDEX fields -> lu); stall_ID and the register stay in idex_stage_reg.

Verification
REQ-032 Reset mid-run: rst_n low with valid_IDEX = 1 -> all outputs 0 asynchronously; release, valid_ID = 1, pc_ID = 0x100 -> pc_IDEX = 0x100 next edge.
REQ-033 Load-use: IDEX lw x5 (mem_rd_en = 1, rd = 5), ID add x6,x5,x1 -> stall_ID = 1 one cycle, bubble (valid_IDEX = 0, ctrl 0), then add loads with rs1_IDEX = 5.
REQ-034 x0 load: IDEX lw with rd = 0, ID rs1 = 0 -> stall_ID = 0, no bubble.
REQ-035 Simultaneous: lu and flush_EX in same cycle -> stall_ID = 0, valid_IDEX = 0 next edge; with IDEX_PERF_CNT_EN, flush_cnt +1, bubble_cnt unchanged.
REQ-036 Hold: hold_MEM high 3 cycles with IDEX pc = 0x200 -> pc_IDEX stays 0x200, stall_ID = 1 throughout; release -> ID instruction loads next edge.
REQ-037 Counter saturation (IDEX_PERF_CNT_EN): bubble_cnt forced to 0xFFFFFFFF, one more lu -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle layout, ALU op encodings and the
// register-index type used by the ID/EX stage and its hazard detector.
package pipeline_pkg;

  localparam int CTRL_W    = 8;
  localparam int REG_IDX_W = 5;

  // Bit positions inside the packed control bundle {alu_op[3:0], alu_src, reg_wr_en, mem_rd_en, mem_wr_en}
  localparam int CTRL_MEM_WR_BIT = 0;
  localparam int CTRL_MEM_RD_BIT = 1;
  localparam int CTRL_REG_WR_BIT = 2;
  localparam int CTRL_ALU_SRC_BIT = 3;
  localparam int CTRL_ALU_OP_LSB = 4;
  localparam int CTRL_ALU_OP_MSB = 7;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_PASS = 4'hA
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_wr_en;
    logic    mem_rd_en;
    logic    mem_wr_en;
  } ctrl_t;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input ctrl_t c);
    return c;
  endfunction

endpackage

// File: rtl/idex_stage_reg_if.sv
// ID -> EX bundle: ID-side fields, pipeline control, the stall request back to
// IF/ID and the registered IDEX fields. Counter outputs exist only with IDEX_PERF_CNT_EN.
interface idex_stage_reg_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = pipeline_pkg::CTRL_W
);

  logic                  valid_ID;
  logic [XLEN-1:0]       pc_ID;
  logic [XLEN-1:0]       rs1_data_ID;
  logic [XLEN-1:0]       rs2_data_ID;
  logic [XLEN-1:0]       imm_ID;
  pipeline_pkg::reg_idx_t rs1_ID;
  pipeline_pkg::reg_idx_t rs2_ID;
  pipeline_pkg::reg_idx_t rd_ID;
  logic [CTRL_W-1:0]     ctrl_ID;

  logic                  flush_EX;
  logic                  hold_MEM;
  logic                  stall_ID;

  logic                  valid_IDEX;
  logic [XLEN-1:0]       pc_IDEX;
  logic [XLEN-1:0]       rs1_data_IDEX;
  logic [XLEN-1:0]       rs2_data_IDEX;
  logic [XLEN-1:0]       imm_IDEX;
  pipeline_pkg::reg_idx_t rs1_IDEX;
  pipeline_pkg::reg_idx_t rs2_IDEX;
  pipeline_pkg::reg_idx_t rd_IDEX;
  logic [CTRL_W-1:0]     ctrl_IDEX;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0]           bubble_cnt;
  logic [31:0]           flush_cnt;
`endif

  // Handshake: there is no valid/ready pair here. valid_ID qualifies the ID
  // fields; stall_ID is the only back-pressure and means "re-present the same
  // ID instruction next cycle". The master must sample stall_ID combinationally.
  modport master (
    output valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID,
           rs1_ID, rs2_ID, rd_ID, ctrl_ID, flush_EX, hold_MEM,
    input  stall_ID, valid_IDEX, pc_IDEX, rs1_data_IDEX, rs2_data_IDEX,
           imm_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX, ctrl_IDEX
`ifdef IDEX_PERF_CNT_EN
    , input bubble_cnt, flush_cnt
`endif
  );

  modport slave (
    input  valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID,
           rs1_ID, rs2_ID, rd_ID, ctrl_ID, flush_EX, hold_MEM,
    output stall_ID, valid_IDEX, pc_IDEX, rs1_data_IDEX, rs2_data_IDEX,
           imm_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX, ctrl_IDEX
`ifdef IDEX_PERF_CNT_EN
    , output bubble_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/idex_hazard_detect.sv
// Combinational load-use detector: a load sitting in IDEX whose destination is
// read by the instruction currently in ID.
module idex_hazard_detect
  import pipeline_pkg::*;
(
  input  logic     valid_ID_i,
  input  reg_idx_t rs1_ID_i,
  input  reg_idx_t rs2_ID_i,
  input  logic     valid_IDEX_i,
  input  logic     mem_rd_en_IDEX_i,
  input  reg_idx_t rd_IDEX_i,
  output logic     lu_o
);

  logic rd_nonzero;
  logic src_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rd_nonzero = (rd_IDEX_i != '0);
  assign src_match  = (rs1_ID_i == rd_IDEX_i) | (rs2_ID_i == rd_IDEX_i);

  assign lu_o = valid_IDEX_i & mem_rd_en_IDEX_i & valid_ID_i & rd_nonzero & src_match;

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with flush, downstream hold and load-use bubble insertion.
// Optional performance counters are enabled by defining IDEX_PERF_CNT_EN.
module idex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = pipeline_pkg::CTRL_W
) (
  input logic              clk,
  input logic              rst_n,
  idex_stage_reg_if.slave  bus
);

  import pipeline_pkg::*;

  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  reg_idx_t          rs1_q,      rs1_d;
  reg_idx_t          rs2_q,      rs2_d;
  reg_idx_t          rd_q,       rd_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;

  logic lu;
  logic do_flush;
  logic do_hold;
  logic do_bubble;
  logic do_load;

  idex_hazard_detect u_hazard (
    .valid_ID_i       (bus.valid_ID),
    .rs1_ID_i         (bus.rs1_ID),
    .rs2_ID_i         (bus.rs2_ID),
    .valid_IDEX_i     (valid_q),
    .mem_rd_en_IDEX_i (ctrl_q[CTRL_MEM_RD_BIT]),
    .rd_IDEX_i        (rd_q),
    .lu_o             (lu)
  );

  // A flush kills the ID instruction anyway, so a coincident load-use must not stall.
  assign bus.stall_ID = (lu & ~bus.flush_EX) | bus.hold_MEM;

  assign do_flush  = bus.flush_EX;
  assign do_hold   = ~bus.flush_EX & bus.hold_MEM;
  assign do_bubble = ~bus.flush_EX & ~bus.hold_MEM & lu;
  assign do_load   = ~bus.flush_EX & ~bus.hold_MEM & ~lu;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    if (do_flush || do_bubble) begin
      // Payload fields stay put; only valid/ctrl are cleared so nothing downstream commits.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (do_load) begin
      valid_d    = bus.valid_ID;
      pc_d       = bus.pc_ID;
      rs1_data_d = bus.rs1_data_ID;
      rs2_data_d = bus.rs2_data_ID;
      imm_d      = bus.imm_ID;
      rs1_d      = bus.rs1_ID;
      rs2_d      = bus.rs2_ID;
      rd_d       = bus.rd_ID;
      ctrl_d     = bus.valid_ID ? bus.ctrl_ID : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign bus.valid_IDEX    = valid_q;
  assign bus.pc_IDEX       = pc_q;
  assign bus.rs1_data_IDEX = rs1_data_q;
  assign bus.rs2_data_IDEX = rs2_data_q;
  assign bus.imm_IDEX      = imm_q;
  assign bus.rs1_IDEX      = rs1_q;
  assign bus.rs2_IDEX      = rs2_q;
  assign bus.rd_IDEX       = rd_q;
  assign bus.ctrl_IDEX     = ctrl_q;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (do_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
    if (do_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed bench for idex_stage_reg: reset, normal load, load-use bubble, x0 load,
// flush vs load-use, hold, flush over hold, async reset mid-stall, optional counters.
module tb_idex_stage_reg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  idex_stage_reg_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  idex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
    bus.valid_ID    = v;
    bus.pc_ID       = pc;
    bus.rs1_data_ID = pc ^ 32'hA5A5_0000;
    bus.rs2_data_ID = pc ^ 32'h0000_5A5A;
    bus.imm_ID      = ~pc;
    bus.rs1_ID      = rs1;
    bus.rs2_ID      = rs2;
    bus.rd_ID       = rd;
    bus.ctrl_ID     = ctrl;
  endtask

  // ctrl encodings: add = 8'h04 (reg_wr), lw = 8'h0E (alu_src, reg_wr, mem_rd)
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.flush_EX = 1'b0;
    bus.hold_MEM = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00);
    #2;
    chk("reset_valid", bus.valid_IDEX, 0);
    chk("reset_pc", bus.pc_IDEX, 0);
    chk("reset_ctrl", bus.ctrl_IDEX, 0);
    chk("reset_stall", bus.stall_ID, 0);
    bus.hold_MEM = 1'b1;
    #1;
    chk("reset_stall_hold", bus.stall_ID, 1);
    bus.hold_MEM = 1'b0;
`ifdef IDEX_PERF_CNT_EN
    chk("reset_bubble_cnt", bus.bubble_cnt, 0);
    chk("reset_flush_cnt", bus.flush_cnt, 0);
`endif
    #5;
    rst_n = 1'b1;

    // normal load
    step();
    set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 8'h04);
    step();
    chk("load_valid", bus.valid_IDEX, 1);
    chk("load_pc", bus.pc_IDEX, 32'h40);
    chk("load_rs1_data", bus.rs1_data_IDEX, 32'hA5A5_0040);
    chk("load_rs2_data", bus.rs2_data_IDEX, 32'h0000_5A1A);
    chk("load_imm", bus.imm_IDEX, 32'hFFFF_FFBF);
    chk("load_rs1", bus.rs1_IDEX, 1);
    chk("load_rs2", bus.rs2_IDEX, 2);
    chk("load_rd", bus.rd_IDEX, 3);
    chk("load_ctrl", bus.ctrl_IDEX, 8'h04);

    // invalid ID: ctrl forced to zero
    set_id(1'b0, 32'h44, 5'd1, 5'd2, 5'd3, 8'h04);
    step();
    chk("inv_valid", bus.valid_IDEX, 0);
    chk("inv_ctrl", bus.ctrl_IDEX, 0);
    chk("inv_pc", bus.pc_IDEX, 32'h44);

    // load-use: lw x5 then add x6,x5,x1
    set_id(1'b1, 32'h50, 5'd2, 5'd0, 5'd5, 8'h0E);
    step();
    set_id(1'b1, 32'h54, 5'd5, 5'd1, 5'd6, 8'h04);
    #1;
    chk("lu_stall", bus.stall_ID, 1);
    step();
    chk("lu_bubble_valid", bus.valid_IDEX, 0);
    chk("lu_bubble_ctrl", bus.ctrl_IDEX, 0);
    chk("lu_stall_clear", bus.stall_ID, 0);
`ifdef IDEX_PERF_CNT_EN
    chk("lu_bubble_cnt", bus.bubble_cnt, 1);
`endif
    step();
    chk("lu_add_valid", bus.valid_IDEX, 1);
    chk("lu_add_rs1", bus.rs1_IDEX, 5);
    chk("lu_add_pc", bus.pc_IDEX, 32'h54);
    chk("lu_add_ctrl", bus.ctrl_IDEX, 8'h04);

    // x0 load never stalls
    set_id(1'b1, 32'h60, 5'd2, 5'd0, 5'd0, 8'h0E);
    step();
    set_id(1'b1, 32'h64, 5'd0, 5'd0, 5'd7, 8'h04);
    #1;
    chk("x0_stall", bus.stall_ID, 0);
    step();
    chk("x0_valid", bus.valid_IDEX, 1);
    chk("x0_pc", bus.pc_IDEX, 32'h64);

    // load-use coincident with flush
    set_id(1'b1, 32'h70, 5'd2, 5'd0, 5'd8, 8'h0E);
    step();
    set_id(1'b1, 32'h74, 5'd1, 5'd8, 5'd9, 8'h04);
    bus.flush_EX = 1'b1;
    #1;
    chk("fl_lu_stall", bus.stall_ID, 0);
    step();
    bus.flush_EX = 1'b0;
    chk("fl_valid", bus.valid_IDEX, 0);
    chk("fl_ctrl", bus.ctrl_IDEX, 0);
    chk("fl_pc_held", bus.pc_IDEX, 32'h70);
`ifdef IDEX_PERF_CNT_EN
    chk("fl_flush_cnt", bus.flush_cnt, 1);
    chk("fl_bubble_cnt", bus.bubble_cnt, 1);
`endif
    step();
    chk("fl_next_valid", bus.valid_IDEX, 1);
    chk("fl_next_pc", bus.pc_IDEX, 32'h74);

    // hold for three cycles
    set_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd10, 8'h04);
    step();
    chk("hold_pre_pc", bus.pc_IDEX, 32'h200);
    set_id(1'b1, 32'h204, 5'd3, 5'd4, 5'd11, 8'h04);
    bus.hold_MEM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", bus.stall_ID, 1);
      step();
      chk("hold_pc", bus.pc_IDEX, 32'h200);
      chk("hold_valid", bus.valid_IDEX, 1);
    end
    bus.hold_MEM = 1'b0;
    #1;
    chk("hold_rel_stall", bus.stall_ID, 0);
    step();
    chk("hold_rel_pc", bus.pc_IDEX, 32'h204);
    chk("hold_rel_rd", bus.rd_IDEX, 11);

    // flush has priority over hold
    bus.flush_EX = 1'b1;
    bus.hold_MEM = 1'b1;
    #1;
    chk("fh_stall", bus.stall_ID, 1);
    step();
    bus.flush_EX = 1'b0;
    bus.hold_MEM = 1'b0;
    chk("fh_valid", bus.valid_IDEX, 0);
    chk("fh_ctrl", bus.ctrl_IDEX, 0);
`ifdef IDEX_PERF_CNT_EN
    chk("fh_flush_cnt", bus.flush_cnt, 2);

    // bubble counter saturation
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    set_id(1'b1, 32'h80, 5'd2, 5'd0, 5'd12, 8'h0E);
    step();
    set_id(1'b1, 32'h84, 5'd12, 5'd1, 5'd13, 8'h04);
    step();
    chk("sat_bubble_valid", bus.valid_IDEX, 0);
    chk("sat_bubble_cnt", bus.bubble_cnt, 32'hFFFF_FFFF);
`endif

    // async reset mid-stall
    set_id(1'b1, 32'h90, 5'd2, 5'd0, 5'd14, 8'h0E);
    step();
    set_id(1'b1, 32'h94, 5'd14, 5'd1, 5'd15, 8'h04);
    #1;
    chk("rst_pre_stall", bus.stall_ID, 1);
    chk("rst_pre_valid", bus.valid_IDEX, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus.valid_IDEX, 0);
    chk("rst_async_pc", bus.pc_IDEX, 0);
    chk("rst_async_rd", bus.rd_IDEX, 0);
    chk("rst_async_ctrl", bus.ctrl_IDEX, 0);
    chk("rst_async_stall", bus.stall_ID, 0);
`ifdef IDEX_PERF_CNT_EN
    chk("rst_async_bubble_cnt", bus.bubble_cnt, 0);
`endif
    #1;
    rst_n = 1'b1;
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 8'h04);
    step();
    chk("rst_post_pc", bus.pc_IDEX, 32'h100);
    chk("rst_post_valid", bus.valid_IDEX, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
